// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//
// Copies one kernel's worth of weights (NUM_W words) from a weight memory into
// a register bank. A load is requested with a single-cycle iStart; the kernel
// is chosen by iKSEL, and its first word sits at iKSEL*NUM_W in the memory.
//
// Ports
//   iCLK      clock, all state on the rising edge
//   iRSTn     asynchronous active-low reset
//   iStart    single-cycle load request (only honoured while idle)
//   iKSEL     kernel select, sampled together with iStart
//   iAbort    synchronous cancel of a load in progress
//   oMemRdEn  weight-memory read enable
//   oMemAddr  weight-memory read address (wraps modulo 2^MEM_AW)
//   iMemData  read data, sampled on the edge one cycle after oMemRdEn
//   oWren     register-bank write enable
//   oADDR     register-bank slot index 0..NUM_W-1
//   oWeight   register-bank write data
//   oBusy     load in progress (fetch and drain phases)
//   oDone     one-cycle load-complete pulse
//
// The memory is expected to present the word for the address driven in cycle
// C by the edge that ends cycle C. Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module weight_loader #(
    parameter int NUM_W  = 25,
    parameter int MEM_AW = 10,
    parameter int DW     = 32
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iStart,
    input  logic [4:0]        iKSEL,
    input  logic              iAbort,
    output logic              oMemRdEn,
    output logic [MEM_AW-1:0] oMemAddr,
    input  logic [DW-1:0]     iMemData,
    output logic              oWren,
    output logic [4:0]        oADDR,
    output logic [DW-1:0]     oWeight,
    output logic              oBusy,
    output logic              oDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] NUM_W_BITS = 32'(NUM_W);
    localparam logic [4:0]  LAST_IDX   = 5'(NUM_W - 1);

    state_t              state_reg,    state_next;
    logic [MEM_AW-1:0]   base_reg,     base_next;
    logic [4:0]          idx_reg,      idx_next;
    logic                rd_en_reg,    rd_en_next;
    logic [MEM_AW-1:0]   mem_addr_reg, mem_addr_next;
    logic                wren_reg,     wren_next;
    logic [4:0]          addr_reg,     addr_next;
    logic [DW-1:0]       weight_reg,   weight_next;
    logic                busy_reg,     busy_next;
    logic                done_reg,     done_next;

    // Kernel base address iKSEL*NUM_W built as a sum of shifted copies of
    // iKSEL, one per set bit of NUM_W. Only shifts below MEM_AW can affect the
    // address because the result is taken modulo 2^MEM_AW.
    logic [MEM_AW+4:0]   ksel_ext;
    logic [MEM_AW-1:0]   base_term [MEM_AW];
    logic [MEM_AW-1:0]   kernel_base;

    assign ksel_ext = {{MEM_AW{1'b0}}, iKSEL};

    genvar gi;
    generate
        for (gi = 0; gi < MEM_AW; gi++) begin : g_base_term
            assign base_term[gi] = NUM_W_BITS[gi] ? MEM_AW'(ksel_ext << gi) : '0;
        end
    endgenerate

    always_comb begin
        kernel_base = '0;
        for (int i = 0; i < MEM_AW; i++) begin
            kernel_base = kernel_base + base_term[i];
        end
    end

    // Next-state and next-output logic. Write-side registers (oADDR, oWeight)
    // and the read address hold their values unless explicitly updated.
    always_comb begin
        state_next    = state_reg;
        base_next     = base_reg;
        idx_next      = idx_reg;
        rd_en_next    = 1'b0;
        mem_addr_next = mem_addr_reg;
        wren_next     = 1'b0;
        addr_next     = addr_reg;
        weight_next   = weight_reg;
        busy_next     = 1'b0;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                // Abort wins over a simultaneous start.
                if (iStart && !iAbort) begin
                    state_next    = FETCH;
                    base_next     = kernel_base;
                    idx_next      = '0;
                    rd_en_next    = 1'b1;
                    mem_addr_next = kernel_base;
                    busy_next     = 1'b1;
                end
            end
            FETCH: begin
                if (!iAbort) begin
                    // The word for the read now on the bus arrives at this
                    // edge; forward it to the bank with the matching index.
                    wren_next   = 1'b1;
                    addr_next   = idx_reg;
                    weight_next = iMemData;
                    busy_next   = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next = DRAIN;
                    end else begin
                        idx_next      = idx_reg + 5'd1;
                        rd_en_next    = 1'b1;
                        mem_addr_next = base_reg + MEM_AW'(idx_reg + 5'd1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                // The last bank write is visible during this state.
                if (!iAbort) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                // A start here is deliberately ignored.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            idx_reg      <= '0;
            rd_en_reg    <= 1'b0;
            mem_addr_reg <= '0;
            wren_reg     <= 1'b0;
            addr_reg     <= '0;
            weight_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            base_reg     <= base_next;
            idx_reg      <= idx_next;
            rd_en_reg    <= rd_en_next;
            mem_addr_reg <= mem_addr_next;
            wren_reg     <= wren_next;
            addr_reg     <= addr_next;
            weight_reg   <= weight_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign oMemRdEn = rd_en_reg;
    assign oMemAddr = mem_addr_reg;
    assign oWren    = wren_reg;
    assign oADDR    = addr_reg;
    assign oWeight  = weight_reg;
    assign oBusy    = busy_reg;
    assign oDone    = done_reg;

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//
// Directed bench for weight_loader. Two instances: the default build
// (MEM_AW=10) and a narrow-address build (MEM_AW=6) for address wrap. Each
// weight memory holds mem[a] = a + 0x100 and returns a word by the edge that
// ends the read cycle; an idle read port returns a poison word.
// Cycle k=1 is the first cycle after the edge that samples iStart.
// -----------------------------------------------------------------------------
module tb_weight_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [4:0]  ksel;
    logic        abort;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        wren;
    logic [4:0]  wr_addr;
    logic [31:0] weight;
    logic        busy;
    logic        done;

    logic        start6;
    logic [4:0]  ksel6;
    logic        mem_rd_en6;
    logic [5:0]  mem_addr6;
    logic [31:0] mem_data6;
    logic        wren6;
    logic [4:0]  wr_addr6;
    logic [31:0] weight6;
    logic        busy6;
    logic        done6;

    int tests_run    = 0;
    int tests_failed = 0;

    weight_loader #(.NUM_W(25), .MEM_AW(10), .DW(32)) dut (
        .iCLK     (clk),
        .iRSTn    (rst_n),
        .iStart   (start),
        .iKSEL    (ksel),
        .iAbort   (abort),
        .oMemRdEn (mem_rd_en),
        .oMemAddr (mem_addr),
        .iMemData (mem_data),
        .oWren    (wren),
        .oADDR    (wr_addr),
        .oWeight  (weight),
        .oBusy    (busy),
        .oDone    (done)
    );

    weight_loader #(.NUM_W(25), .MEM_AW(6), .DW(32)) dut6 (
        .iCLK     (clk),
        .iRSTn    (rst_n),
        .iStart   (start6),
        .iKSEL    (ksel6),
        .iAbort   (1'b0),
        .oMemRdEn (mem_rd_en6),
        .oMemAddr (mem_addr6),
        .iMemData (mem_data6),
        .oWren    (wren6),
        .oADDR    (wr_addr6),
        .oWeight  (weight6),
        .oBusy    (busy6),
        .oDone    (done6)
    );

    // Weight memories: mem[a] = a + 0x100.
    always @(negedge clk) begin
        mem_data  <= mem_rd_en  ? 32'h100 + 32'(mem_addr)  : 32'hDEAD_BEEF;
        mem_data6 <= mem_rd_en6 ? 32'h100 + 32'(mem_addr6) : 32'hDEAD_BEEF;
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        ksel   = 5'd0;
        abort  = 1'b0;
        start6 = 1'b0;
        ksel6  = 5'd0;
        #12;
        tests_run++;
        if ({mem_rd_en, mem_addr, wren, wr_addr, weight, busy, done} !== 51'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {mem_rd_en, mem_addr, wren, wr_addr, weight, busy, done});
        end
        tests_run++;
        if ({mem_rd_en6, mem_addr6, wren6, wr_addr6, weight6, busy6, done6} !== 47'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs6: got %h, expected 0",
                     {mem_rd_en6, mem_addr6, wren6, wr_addr6, weight6, busy6, done6});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] reset checked");
    endtask

    // Full load of kernel k_sel on the default instance. iStart is re-pulsed
    // in cycles pulse_a / pulse_b (0 = never) to show it is ignored while busy
    // or in the done cycle. iKSEL is scrambled right after the start edge.
    task automatic test_load(input logic [4:0] k_sel, input int pulse_a, input int pulse_b);
        int          base;
        int          n_writes;
        logic        exp_rd, exp_wr, exp_busy, exp_done;
        logic [9:0]  exp_maddr;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_w;
        base     = (int'(k_sel) * 25) % 1024;
        n_writes = 0;
        start = 1'b1;
        ksel  = k_sel;
        @(posedge clk);
        #1;
        start = 1'b0;
        ksel  = ~k_sel;
        for (int k = 1; k <= 28; k++) begin
            exp_rd    = (k <= 25);
            exp_wr    = (k >= 2) && (k <= 26);
            exp_busy  = (k <= 26);
            exp_done  = (k == 27);
            exp_maddr = 10'((base + ((k <= 25) ? k - 1 : 24)) % 1024);
            exp_waddr = 5'((k <= 26) ? k - 2 : 24);
            exp_w     = 32'h100 + 32'((base + int'(exp_waddr)) % 1024);
            if (wren === 1'b1) n_writes++;
            tests_run++;
            if ({mem_rd_en, wren, busy, done} !== {exp_rd, exp_wr, exp_busy, exp_done}) begin
                tests_failed++;
                $display("FAIL load_ctrl k=%0d cycle=%0d: rd/wr/busy/done=%b, expected %b",
                         k_sel, k, {mem_rd_en, wren, busy, done}, {exp_rd, exp_wr, exp_busy, exp_done});
            end
            tests_run++;
            if (mem_addr !== exp_maddr) begin
                tests_failed++;
                $display("FAIL load_maddr k=%0d cycle=%0d: got %0d, expected %0d",
                         k_sel, k, mem_addr, exp_maddr);
            end
            if (k >= 2) begin
                tests_run++;
                if (wr_addr !== exp_waddr || weight !== exp_w) begin
                    tests_failed++;
                    $display("FAIL load_write k=%0d cycle=%0d: addr=%0d data=%h, expected addr=%0d data=%h",
                             k_sel, k, wr_addr, weight, exp_waddr, exp_w);
                end
            end
            start = (k == pulse_a) || (k == pulse_b);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        tests_run++;
        if (n_writes != 25) begin
            tests_failed++;
            $display("FAIL load_count k=%0d: %0d writes, expected 25", k_sel, n_writes);
        end
        $display("[TB] load ksel=%0d base=%0d writes=%0d", k_sel, base, n_writes);
    endtask

    task automatic test_abort();
        // ksel=1, base 25; abort sampled at the end of cycle 10.
        int dones;
        start = 1'b1;
        ksel  = 5'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        tests_run++;
        if ({mem_rd_en, wren, busy, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL abort_ctrl: rd/wr/busy/done=%b, expected 0000", {mem_rd_en, wren, busy, done});
        end
        tests_run++;
        if (wr_addr !== 5'd8 || weight !== 32'h121 || mem_addr !== 10'd34) begin
            tests_failed++;
            $display("FAIL abort_hold: addr=%0d data=%h maddr=%0d, expected 8 121 34",
                     wr_addr, weight, mem_addr);
        end
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1 || wren === 1'b1 || busy === 1'b1) dones++;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: %0d active cycles after abort, expected 0", dones);
        end
        $display("[TB] abort at cycle 10 checked");
    endtask

    task automatic test_abort_start_idle();
        start = 1'b1;
        abort = 1'b1;
        ksel  = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        tests_run++;
        if ({mem_rd_en, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_start_idle: rd/busy=%b, expected 00", {mem_rd_en, busy});
        end
        @(posedge clk);
        #1;
        $display("[TB] abort+start in idle checked");
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        ksel  = 5'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_rd_en, mem_addr, wren, wr_addr, weight, busy, done} !== 51'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: got %h, expected 0",
                     {mem_rd_en, mem_addr, wren, wr_addr, weight, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] mid-load reset checked");
    endtask

    task automatic test_wrap();
        // MEM_AW=6, ksel=2: base 50, reads 50..63 then 0..10.
        int          n_writes;
        logic        exp_rd, exp_wr, exp_done;
        logic [5:0]  exp_maddr;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_w;
        n_writes = 0;
        start6 = 1'b1;
        ksel6  = 5'd2;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        ksel6  = 5'd9;
        for (int k = 1; k <= 28; k++) begin
            exp_rd    = (k <= 25);
            exp_wr    = (k >= 2) && (k <= 26);
            exp_done  = (k == 27);
            exp_maddr = 6'((50 + ((k <= 25) ? k - 1 : 24)) % 64);
            exp_waddr = 5'((k <= 26) ? k - 2 : 24);
            exp_w     = 32'h100 + 32'((50 + int'(exp_waddr)) % 64);
            if (wren6 === 1'b1) n_writes++;
            tests_run++;
            if ({mem_rd_en6, wren6, done6} !== {exp_rd, exp_wr, exp_done} || mem_addr6 !== exp_maddr) begin
                tests_failed++;
                $display("FAIL wrap_read cycle=%0d: rd/wr/done=%b maddr=%0d, expected %b %0d",
                         k, {mem_rd_en6, wren6, done6}, mem_addr6, {exp_rd, exp_wr, exp_done}, exp_maddr);
            end
            if (k >= 2) begin
                tests_run++;
                if (wr_addr6 !== exp_waddr || weight6 !== exp_w) begin
                    tests_failed++;
                    $display("FAIL wrap_write cycle=%0d: addr=%0d data=%h, expected addr=%0d data=%h",
                             k, wr_addr6, weight6, exp_waddr, exp_w);
                end
            end
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (n_writes != 25) begin
            tests_failed++;
            $display("FAIL wrap_count: %0d writes, expected 25", n_writes);
        end
        $display("[TB] wrap load ksel=2 base=50 writes=%0d", n_writes);
    endtask

    initial begin
        test_reset();
        test_load(5'd0, 0, 0);
        test_load(5'd3, 5, 27);
        test_abort();
        test_load(5'd1, 0, 0);
        test_abort_start_idle();
        test_reset_mid();
        test_load(5'd2, 0, 0);
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter NUM_W, default 25, meaning number of kernel weights per load.
REQ-002 SHALL have parameter MEM_AW, default 10, meaning weight-memory address width.
REQ-003 SHALL have parameter DW, default 32, meaning weight data width.
REQ-004 SHALL have port iCLK  input  1  clock, all state on rising edge.
REQ-005 SHALL have port iRSTn  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port iStart  input  1  single-cycle load request.
REQ-007 SHALL have port iKSEL  input  5  kernel select, sampled with iStart.
REQ-008 SHALL have port iAbort  input  1  synchronous cancel of a load in progress.
REQ-009 SHALL have port oMemRdEn  output  1  weight-memory read enable.
REQ-010 SHALL have port oMemAddr  output  MEM_AW  weight-memory read address.
REQ-011 SHALL have port iMemData  input  DW  read data, valid exactly 1 cycle after oMemRdEn.
REQ-012 SHALL have port oWren  output  1  register-bank write enable.
REQ-013 SHALL have port oADDR  output  5  register-bank slot index (0..NUM_W-1).
REQ-014 SHALL have port oWeight  output  DW  register-bank write data.
REQ-015 SHALL have port oBusy  output  1  load in progress.
REQ-016 SHALL have port oDone  output  1  one-cycle load-complete pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, DONE; all outputs registered.
REQ-018 IDLE: iStart=1 at edge T SHALL latch base = iKSEL*NUM_W (modulo 2^MEM_AW, shift-add, no multiplier), clear index, enter FETCH.
REQ-019 FETCH: oMemRdEn=1, oMemAddr=base+idx (wraps modulo 2^MEM_AW), idx 0..NUM_W-1, one read per cycle, cycles T+1..T+NUM_W.
REQ-020 Each read issued in cycle C SHALL produce oWren=1, oADDR=idx, oWeight=iMemData in cycle C+1; oWren cycles T+2..T+NUM_W+1, oADDR strictly 0,1,..,NUM_W-1, no gaps.
REQ-021 After last read, FETCH->DRAIN; DRAIN covers the final write cycle, then ->DONE.
REQ-022 DONE: oDone=1 for exactly one cycle (T+NUM_W+2), then ->IDLE.
REQ-023 oBusy SHALL be 1 in FETCH and DRAIN (T+1..T+NUM_W+1), 0 in IDLE and DONE.
REQ-024 iStart outside IDLE SHALL be ignored; iKSEL changes after T SHALL not affect the load.
REQ-025 iStart in the DONE cycle SHALL be ignored; a new start is accepted earliest one cycle after oDone.
REQ-026 iAbort=1 in FETCH or DRAIN SHALL, at that edge, go to IDLE, drive oMemRdEn=0, oWren=0, oBusy=0, no oDone; a write already sampled by the bank remains.
REQ-027 iAbort and iStart together in IDLE: iAbort has priority, no load starts; iAbort in IDLE/DONE otherwise has no effect.
REQ-028 When oWren=0, oADDR and oWeight SHALL hold their last values; oMemAddr holds when oMemRdEn=0.

Reset
REQ-029 iRSTn=0 SHALL asynchronously force IDLE and zero oMemRdEn, oMemAddr, oWren, oADDR, oWeight, oBusy, oDone, base and index.
REQ-030 Reset mid-load SHALL abandon the load; first iStart after release starts a full NUM_W load from index 0.

Verification
REQ-031 Memory preloaded mem[a]=a+0x100; iStart, iKSEL=0 at T -> reads addr 0..24 at T+1..T+25; writes (ADDR k, data 0x100+k) at T+2..T+26; oDone at T+27 only.
REQ-032 iKSEL=3 -> oMemAddr 75..99; oADDR 0..24; oWeight = mem[75+k].
REQ-033 MEM_AW=6, iKSEL=2 (base 50) -> oMemAddr 50..63 then 0..10; 25 writes, no gaps.
REQ-034 iAbort at T+10 -> oWren=0 and oBusy=0 from T+10 edge onward, no oDone; next iStart performs a complete 25-write load.
REQ-035 iStart re-pulsed at T+5 and in DONE cycle -> ignored; exactly 25 writes, one oDone.
REQ-036 iRSTn low at T+12 -> all outputs 0 immediately (asynchronous); after release, new load completes normally with oADDR from 0.
